// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types, limits and helpers for the N-channel cacheline memory arbiter.
package mem_arbiter_rr_pkg;

  localparam int ARB_MAX_CH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_t;

  // Round-robin pointer successor: the channel after the winner, wrapping to 0.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned num_ch);
    return (idx == num_ch - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Client-side and DFP-side bus bundle of the memory arbiter.
interface mem_arbiter_rr_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);

  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*LINE_W-1:0] ch_wdata;
  logic [LINE_W-1:0]        ch_rdata;
  logic [NUM_CH-1:0]        ch_resp;
  logic [ADDR_W-1:0]        dfp_addr;
  logic                     dfp_read;
  logic                     dfp_write;
  logic [LINE_W-1:0]        dfp_wdata;
  logic [LINE_W-1:0]        dfp_rdata;
  logic                     dfp_resp;

  // Arbiter view: owns the DFP request side and the client completion side.
  modport master (
    input  ch_addr, ch_read, ch_write, ch_wdata, dfp_rdata, dfp_resp,
    output ch_rdata, ch_resp, dfp_addr, dfp_read, dfp_write, dfp_wdata
  );

  modport slave (
    output ch_addr, ch_read, ch_write, ch_wdata, dfp_rdata, dfp_resp,
    input  ch_rdata, ch_resp, dfp_addr, dfp_read, dfp_write, dfp_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_rr_pick.sv
// Combinational winner pick: rotate requests by the pointer, priority-encode, un-rotate.
module mem_arbiter_rr_rr_pick #(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  input  logic                      mode,
  output logic                      valid,
  output logic [NUM_CH-1:0]         gnt,
  output logic [$clog2(NUM_CH)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0]    base;
  logic [IDX_W-1:0]    rot_idx;
  logic [2*NUM_CH-1:0] req_dbl;
  logic [NUM_CH-1:0]   req_rot;
  logic [IDX_W:0]      sum;

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    base    = mode ? ptr : '0;
    req_dbl = {req, req};
    req_rot = req_dbl[base +: NUM_CH];
    valid   = |req;
    rot_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) rot_idx = IDX_W'(i);
    end
    sum = {1'b0, rot_idx} + {1'b0, base};
    if (sum >= (IDX_W+1)'(NUM_CH)) sum = sum - (IDX_W+1)'(NUM_CH);
    idx = sum[IDX_W-1:0];
    gnt = '0;
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-channel cacheline arbiter onto a single DFP port; one outstanding transaction,
// request captured at grant, registered read data and one-cycle completion pulse.
module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter bit RR_MODE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  mem_arbiter_rr_if.master          bus,
  output logic                      busy,
  output logic [$clog2(NUM_CH)-1:0] gnt_id
);

  localparam int IDX_W = $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > ARB_MAX_CH) begin : g_bad_num_ch
    $error("mem_arbiter_rr: NUM_CH must be in 2..ARB_MAX_CH");
  end

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  gnt_id_q, gnt_id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              is_write_q, is_write_d;

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] pick_gnt;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [ADDR_W-1:0] pick_addr;
  logic [LINE_W-1:0] pick_wdata;

  assign req = bus.ch_read | bus.ch_write;

  mem_arbiter_rr_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .mode  (RR_MODE),
    .valid (pick_valid),
    .gnt   (pick_gnt),
    .idx   (pick_idx)
  );

  // One-hot AND-OR select of the winning channel's address and write line.
  always_comb begin
    pick_addr  = '0;
    pick_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_gnt[i]) begin
        pick_addr  = bus.ch_addr[i*ADDR_W +: ADDR_W];
        pick_wdata = bus.ch_wdata[i*LINE_W +: LINE_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_id_d   = gnt_id_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    is_write_d = is_write_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_id_d   = pick_idx;
          addr_d     = pick_addr;
          wdata_d    = pick_wdata;
          // A channel raising both read and write is served as a write.
          is_write_d = |(pick_gnt & bus.ch_write);
          rr_ptr_d   = IDX_W'(next_ptr(32'(pick_idx), NUM_CH));
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.dfp_resp) begin
          if (!is_write_q) rdata_d = bus.dfp_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: capture registers are reset too, so dfp_* and ch_rdata read 0 out of reset rather than X.
  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_id_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_id_q   <= gnt_id_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      is_write_q <= is_write_d;
    end
  end

  always_comb begin
    bus.ch_resp = '0;
    if (state_q == RESP) bus.ch_resp[gnt_id_q] = 1'b1;
  end

  assign bus.ch_rdata  = rdata_q;
  assign bus.dfp_addr  = addr_q;
  assign bus.dfp_wdata = wdata_q;
  assign bus.dfp_read  = (state_q == ISSUE) && !is_write_q;
  assign bus.dfp_write = (state_q == ISSUE) && is_write_q;
  assign busy          = (state_q != IDLE);
  assign gnt_id        = gnt_id_q;

  always @(posedge clk) begin
    if (rst) begin
      assert (!(|(bus.ch_read & bus.ch_write)))
        else $warning("mem_arbiter_rr: read and write both high on one channel, served as write");
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr: 2-ch round-robin, 4-ch round-robin and 4-ch fixed-priority instances.
module tb_mem_arbiter_rr;

  localparam int AW = 32;
  localparam int LW = 256;

  typedef logic [LW-1:0] line_t;
  typedef struct {
    int    ch;
    line_t rdata;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       busy2, busy4, busy4f;
  logic [0:0] gnt2;
  logic [1:0] gnt4, gnt4f;

  mem_arbiter_rr_if #(.NUM_CH(2), .ADDR_W(AW), .LINE_W(LW)) if2 ();
  mem_arbiter_rr_if #(.NUM_CH(4), .ADDR_W(AW), .LINE_W(LW)) if4 ();
  mem_arbiter_rr_if #(.NUM_CH(4), .ADDR_W(AW), .LINE_W(LW)) if4f ();

  mem_arbiter_rr #(.NUM_CH(2), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1'b1)) dut2 (
    .clk(clk), .rst(rst), .bus(if2), .busy(busy2), .gnt_id(gnt2));
  mem_arbiter_rr #(.NUM_CH(4), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1'b1)) dut4 (
    .clk(clk), .rst(rst), .bus(if4), .busy(busy4), .gnt_id(gnt4));
  mem_arbiter_rr #(.NUM_CH(4), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1'b0)) dut4f (
    .clk(clk), .rst(rst), .bus(if4f), .busy(busy4f), .gnt_id(gnt4f));

  int    tests;
  int    fails;
  exp_t  q2[$];
  exp_t  q4[$];
  exp_t  q4f[$];
  line_t mem_data2;
  int    cnt2, cnt4, cnt4f;
  int    rr_order[6] = '{0, 1, 2, 3, 0, 1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input line_t act, input line_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_resp(input int which, input int n);
    int seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      case (which)
        2:       if (|if2.ch_resp) seen++;
        4:       if (|if4.ch_resp) seen++;
        default: if (|if4f.ch_resp) seen++;
      endcase
      if (seen == n) return;
    end
    tests++;
    fails++;
    $display("FAIL wait_resp%0d: got %0d responses expected %0d", which, seen, n);
  endtask

  // Memory models: respond on the third negedge of a DFP request; resp becomes visible at the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      cnt2 = 0; if2.dfp_resp = 1'b0; if2.dfp_rdata = '0;
    end else begin
      if2.dfp_resp = 1'b0;
      if (if2.dfp_read || if2.dfp_write) begin
        cnt2++;
        if (cnt2 == 3) begin if2.dfp_rdata = mem_data2; if2.dfp_resp = 1'b1; end
      end else cnt2 = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      cnt4 = 0; if4.dfp_resp = 1'b0; if4.dfp_rdata = '0;
    end else begin
      if4.dfp_resp = 1'b0;
      if (if4.dfp_read || if4.dfp_write) begin
        cnt4++;
        if (cnt4 == 3) begin if4.dfp_rdata = {8{if4.dfp_addr}}; if4.dfp_resp = 1'b1; end
      end else cnt4 = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      cnt4f = 0; if4f.dfp_resp = 1'b0; if4f.dfp_rdata = '0;
    end else begin
      if4f.dfp_resp = 1'b0;
      if (if4f.dfp_read || if4f.dfp_write) begin
        cnt4f++;
        if (cnt4f == 3) begin if4f.dfp_rdata = {8{if4f.dfp_addr}}; if4f.dfp_resp = 1'b1; end
      end else cnt4f = 0;
    end
  end

  // Scoreboard monitors: pop one expectation per completion pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst && |if2.ch_resp) begin
      if (q2.size() == 0) begin
        tests++; fails++;
        $display("FAIL resp2_unexpected: got ch_resp=%b expected none", if2.ch_resp);
      end else begin
        e = q2.pop_front();
        check("resp2_ch", line_t'(if2.ch_resp), line_t'(1 << e.ch));
        check("resp2_rdata", if2.ch_rdata, e.rdata);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && |if4.ch_resp) begin
      if (q4.size() == 0) begin
        tests++; fails++;
        $display("FAIL resp4_unexpected: got ch_resp=%b expected none", if4.ch_resp);
      end else begin
        e = q4.pop_front();
        check("resp4_ch", line_t'(if4.ch_resp), line_t'(1 << e.ch));
        check("resp4_rdata", if4.ch_rdata, e.rdata);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && |if4f.ch_resp) begin
      if (q4f.size() == 0) begin
        tests++; fails++;
        $display("FAIL resp4f_unexpected: got ch_resp=%b expected none", if4f.ch_resp);
      end else begin
        e = q4f.pop_front();
        check("resp4f_ch", line_t'(if4f.ch_resp), line_t'(1 << e.ch));
        check("resp4f_rdata", if4f.ch_rdata, e.rdata);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    mem_data2 = '0;
    if2.ch_addr = '0;  if2.ch_read = '0;  if2.ch_write = '0;  if2.ch_wdata = '0;
    if4.ch_addr = '0;  if4.ch_read = '0;  if4.ch_write = '0;  if4.ch_wdata = '0;
    if4f.ch_addr = '0; if4f.ch_read = '0; if4f.ch_write = '0; if4f.ch_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", busy2, 0);
    check("rst_gnt_id", gnt2, 0);
    check("rst_ch_resp", if2.ch_resp, 0);
    check("rst_ch_rdata", if2.ch_rdata, 0);
    check("rst_dfp_read", if2.dfp_read, 0);
    check("rst_dfp_write", if2.dfp_write, 0);
    check("rst_dfp_addr", if2.dfp_addr, 0);
    check("rst_dfp_wdata", if2.dfp_wdata, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single read on channel 0
    mem_data2 = {32{8'hA5}};
    if2.ch_addr[0 +: AW] = 32'h0000_1040;
    if2.ch_read = 2'b01;
    q2.push_back('{ch: 0, rdata: {32{8'hA5}}});
    @(negedge clk);
    check("rd_dfp_read", if2.dfp_read, 1);
    check("rd_dfp_write", if2.dfp_write, 0);
    check("rd_dfp_addr", if2.dfp_addr, 32'h0000_1040);
    check("rd_busy", busy2, 1);
    check("rd_gnt_id", gnt2, 0);
    wait_resp(2, 1);
    check("rd_dfp_read_drop", if2.dfp_read, 0);
    if2.ch_read = '0;
    @(negedge clk);
    check("rd_busy_low", busy2, 0);
    check("rd_resp_low", if2.ch_resp, 0);

    // Write on channel 1; client changes addr/wdata after the grant
    mem_data2 = {32{8'h5A}};
    if2.ch_addr[AW +: AW]  = 32'h0000_2080;
    if2.ch_wdata[LW +: LW] = {8{32'hDEAD_BEEF}};
    if2.ch_write = 2'b10;
    q2.push_back('{ch: 1, rdata: {32{8'hA5}}});
    @(negedge clk);
    check("wr_dfp_write", if2.dfp_write, 1);
    check("wr_dfp_read", if2.dfp_read, 0);
    check("wr_dfp_addr", if2.dfp_addr, 32'h0000_2080);
    check("wr_dfp_wdata", if2.dfp_wdata, {8{32'hDEAD_BEEF}});
    check("wr_gnt_id", gnt2, 1);
    if2.ch_addr[AW +: AW]  = 32'h0000_03C0;
    if2.ch_wdata[LW +: LW] = {8{32'h1234_5678}};
    @(negedge clk);
    check("wr_hold_addr", if2.dfp_addr, 32'h0000_2080);
    check("wr_hold_wdata", if2.dfp_wdata, {8{32'hDEAD_BEEF}});
    check("wr_hold_write", if2.dfp_write, 1);
    wait_resp(2, 1);
    if2.ch_write = '0;
    @(negedge clk);

    // Round-robin fairness, all four channels reading continuously
    for (int i = 0; i < 4; i++) if4.ch_addr[i*AW +: AW] = 32'h100 * (i + 1);
    for (int k = 0; k < 6; k++) begin
      a = 32'h100 * (rr_order[k] + 1);
      q4.push_back('{ch: rr_order[k], rdata: {8{a}}});
    end
    if4.ch_read = 4'hF;
    wait_resp(4, 4);
    check("rr_ptr_wrap", dut4.rr_ptr_q, 0);
    wait_resp(4, 2);
    if4.ch_read = '0;
    check("rr_ptr_final", dut4.rr_ptr_q, 2);
    @(negedge clk);
    check("rr_busy_low", busy4, 0);

    // Fixed priority: ch1 keeps winning over ch3 until it drops
    if4f.ch_addr[1*AW +: AW] = 32'h0000_1100;
    if4f.ch_addr[3*AW +: AW] = 32'h0000_3300;
    for (int k = 0; k < 3; k++) q4f.push_back('{ch: 1, rdata: {8{32'h0000_1100}}});
    q4f.push_back('{ch: 3, rdata: {8{32'h0000_3300}}});
    if4f.ch_read = 4'b1010;
    wait_resp(5, 3);
    if4f.ch_read = 4'b1000;
    wait_resp(5, 1);
    if4f.ch_read = '0;
    @(negedge clk);

    // Read+write on one channel, then asynchronous reset mid-ISSUE
    if2.ch_addr[0 +: AW]  = 32'h0000_4000;
    if2.ch_wdata[0 +: LW] = {8{32'hCAFE_F00D}};
    if2.ch_read  = 2'b01;
    if2.ch_write = 2'b01;
    @(negedge clk);
    check("rw_dfp_write", if2.dfp_write, 1);
    check("rw_dfp_read", if2.dfp_read, 0);
    check("rw_rr_ptr", dut2.rr_ptr_q, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_dfp_write", if2.dfp_write, 0);
    check("arst_dfp_read", if2.dfp_read, 0);
    check("arst_dfp_addr", if2.dfp_addr, 0);
    check("arst_ch_resp", if2.ch_resp, 0);
    check("arst_ch_rdata", if2.ch_rdata, 0);
    check("arst_busy", busy2, 0);
    check("arst_rr_ptr", dut2.rr_ptr_q, 0);
    if2.ch_read  = '0;
    if2.ch_write = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mem_data2 = {8{32'h0BAD_CAFE}};
    if2.ch_addr[AW +: AW] = 32'h0000_5040;
    if2.ch_read = 2'b10;
    q2.push_back('{ch: 1, rdata: {8{32'h0BAD_CAFE}}});
    @(negedge clk);
    check("post_gnt_id", gnt2, 1);
    check("post_dfp_read", if2.dfp_read, 1);
    check("post_dfp_addr", if2.dfp_addr, 32'h0000_5040);
    wait_resp(2, 1);
    if2.ch_read = '0;
    repeat (2) @(negedge clk);

    check("q2_drained", q2.size(), 0);
    check("q4_drained", q4.size(), 0);
    check("q4f_drained", q4f.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
